// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    ERROR = 2'd3
  } fetch_state_t;

  localparam logic [31:0] HALT_INST            = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_1000;
  localparam logic [31:0] DEFAULT_PC_STEP      = 32'd4;

endpackage

// File: rtl/fetch_debug_counters.sv
// Debug cycle counter and last-accepted-instruction capture for the fetch stage.
// Only present when FETCH_SEQ_DEBUG_EN is defined.
`ifdef FETCH_SEQ_DEBUG_EN
module fetch_debug_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_en,
  input  logic        accept,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  output logic [31:0] system_counter,
  output logic [31:0] last_pc,
  output logic [31:0] last_inst
);

  always_ff @(posedge clk) begin
    if (rst) begin
      system_counter <= '0;
      last_pc        <= '0;
      last_inst      <= '0;
    end else begin
      if (count_en) system_counter <= system_counter + 32'd1;
      if (accept) begin
        last_pc   <= pc;
        last_inst <= inst;
      end
    end
  end

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// PC owner and fetch-stage sequencer (BOOT/RUN/HALT/ERROR).
// Optional debug counters are built when FETCH_SEQ_DEBUG_EN is defined.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] PC_STEP      = DEFAULT_PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] inst,
  input  logic        mem_err,
  output logic [31:0] pc,
  output logic        if_valid,
  output logic        flush,
  output logic        halt,
  output logic        err,
  output logic [31:0] system_counter,
  output logic [31:0] last_pc,
  output logic [31:0] last_inst
);

  fetch_state_t state, state_next;
  logic [31:0]  pc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc    <= RESET_VECTOR;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Priority: memory error, misaligned redirect, redirect, halt, stall, step.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    flush      = 1'b0;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (mem_err) begin
          state_next = ERROR;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
          state_next = ERROR;
        end else if (redirect_valid) begin
          flush   = 1'b1;
          pc_next = redirect_pc;
        end else if ((inst == HALT_INST) && !stall) begin
          state_next = HALT;
        end else if (!stall) begin
          pc_next = pc + PC_STEP;
        end
      end
      default: ;
    endcase
  end

  assign if_valid = (state == RUN);
  assign halt     = (state == HALT) || (state == ERROR);
  assign err      = (state == ERROR);

`ifdef FETCH_SEQ_DEBUG_EN
  logic accept;
  logic count_en;

  assign accept   = if_valid & ~stall & ~flush & ~mem_err;
  assign count_en = (state == BOOT) || (state == RUN);

  fetch_debug_counters u_debug (
    .clk            (clk),
    .rst            (rst),
    .count_en       (count_en),
    .accept         (accept),
    .pc             (pc),
    .inst           (inst),
    .system_counter (system_counter),
    .last_pc        (last_pc),
    .last_inst      (last_inst)
  );
`else
  assign system_counter = '0;
  assign last_pc        = '0;
  assign last_inst      = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; debug expectations follow FETCH_SEQ_DEBUG_EN.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic        mem_err;
  logic [31:0] pc;
  logic        if_valid;
  logic        flush;
  logic        halt;
  logic        err;
  logic [31:0] system_counter;
  logic [31:0] last_pc;
  logic [31:0] last_inst;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] NOP_INST = 32'h2108_0001;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst           (inst),
    .mem_err        (mem_err),
    .pc             (pc),
    .if_valid       (if_valid),
    .flush          (flush),
    .halt           (halt),
    .err            (err),
    .system_counter (system_counter),
    .last_pc        (last_pc),
    .last_inst      (last_inst)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Debug outputs are tied to zero when the feature is not built.
  task automatic chk_dbg(input string tag, input logic [31:0] obs, input logic [31:0] exp_en);
`ifdef FETCH_SEQ_DEBUG_EN
    chk(tag, obs, exp_en);
`else
    chk(tag, obs, 32'h0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    inst = NOP_INST; mem_err = 1'b0;

    // Reset sequence: two cycles of rst, then one BOOT cycle.
    tick(); tick();
    chk("rst_pc", pc, 32'h1000);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_flush", {31'b0, flush}, 32'd0);
    chk("rst_halt", {31'b0, halt}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_cnt", system_counter, 32'd0);
    chk("rst_last_pc", last_pc, 32'd0);
    chk("rst_last_inst", last_inst, 32'd0);
    rst = 1'b0; #1;
    chk("boot_if_valid", {31'b0, if_valid}, 32'd0);
    chk("boot_pc", pc, 32'h1000);
    tick();
    chk("run0_if_valid", {31'b0, if_valid}, 32'd1);
    chk("run0_pc", pc, 32'h1000);
    tick();
    chk("run1_pc", pc, 32'h1004);
    tick();
    chk("run2_pc", pc, 32'h1008);

    // Stall three cycles at 0x1008, released in the fourth.
    stall = 1'b1; #1;
    chk("stall1_pc", pc, 32'h1008);
    tick();
    chk("stall2_pc", pc, 32'h1008);
    tick();
    chk("stall3_pc", pc, 32'h1008);
    chk_dbg("stall3_cnt", system_counter, 32'd5);
    tick();
    stall = 1'b0; #1;
    chk("unstall_pc", pc, 32'h1008);
    tick();
    chk("step_after_stall_pc", pc, 32'h100C);
    chk_dbg("step_after_stall_cnt", system_counter, 32'd7);
    chk_dbg("step_after_stall_last_pc", last_pc, 32'h1008);
    tick();
    chk("pre_halt_pc", pc, 32'h1010);

    // Halt encoding at 0x1010.
    inst = 32'h0000_0000; #1;
    chk("halt_inst_if_valid", {31'b0, if_valid}, 32'd1);
    chk("halt_inst_halt", {31'b0, halt}, 32'd0);
    tick();
    inst = NOP_INST;
    chk("halt_halt", {31'b0, halt}, 32'd1);
    chk("halt_pc", pc, 32'h1010);
    chk("halt_if_valid", {31'b0, if_valid}, 32'd0);
    chk("halt_err", {31'b0, err}, 32'd0);
    chk_dbg("halt_last_inst", last_inst, 32'h0);
    chk_dbg("halt_last_pc", last_pc, 32'h1010);
    redirect_valid = 1'b1; redirect_pc = 32'h3000; #1;
    chk("halt_redirect_flush", {31'b0, flush}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    chk("halt_redirect_pc", pc, 32'h1010);
    chk("halt_sticky", {31'b0, halt}, 32'd1);
    chk_dbg("halt_cnt_frozen", system_counter, 32'd9);

    // Redirect during stall from 0x1004.
    do_reset();
    tick(); tick();
    chk("redir_start_pc", pc, 32'h1004);
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h2000; #1;
    chk("redir_flush", {31'b0, flush}, 32'd1);
    tick();
    stall = 1'b0; redirect_valid = 1'b0; #1;
    chk("redir_pc", pc, 32'h2000);
    chk("redir_if_valid", {31'b0, if_valid}, 32'd1);
    chk("redir_flush_clear", {31'b0, flush}, 32'd0);
    chk_dbg("redir_last_pc", last_pc, 32'h1000);
    for (int i = 0; i < 16; i++) tick();
    chk("run_to_2040_pc", pc, 32'h2040);

    // Mid-run reset from RUN.
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("midrst_pc", pc, 32'h1000);
    chk("midrst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("midrst_cnt", system_counter, 32'd0);
    tick();
    chk("midrst_run_if_valid", {31'b0, if_valid}, 32'd1);
    tick(); tick();
    chk("memerr_start_pc", pc, 32'h1008);

    // Memory error at 0x1008.
    mem_err = 1'b1; #1;
    chk("memerr_flush", {31'b0, flush}, 32'd0);
    tick();
    mem_err = 1'b0; #1;
    chk("memerr_err", {31'b0, err}, 32'd1);
    chk("memerr_halt", {31'b0, halt}, 32'd1);
    chk("memerr_if_valid", {31'b0, if_valid}, 32'd0);
    chk("memerr_pc", pc, 32'h1008);
    redirect_valid = 1'b1; redirect_pc = 32'h4000; #1;
    chk("memerr_redirect_flush", {31'b0, flush}, 32'd0);
    tick();
    redirect_valid = 1'b0; #1;
    chk("memerr_sticky_err", {31'b0, err}, 32'd1);
    chk("memerr_sticky_pc", pc, 32'h1008);

    // Reset out of ERROR.
    do_reset();
    chk("errrst_err", {31'b0, err}, 32'd0);
    chk("errrst_halt", {31'b0, halt}, 32'd0);
    chk("errrst_pc", pc, 32'h1000);
    chk("errrst_if_valid", {31'b0, if_valid}, 32'd0);
    tick();

    // Misaligned redirect.
    redirect_valid = 1'b1; redirect_pc = 32'h2002; #1;
    chk("misalign_flush", {31'b0, flush}, 32'd0);
    tick();
    redirect_valid = 1'b0; #1;
    chk("misalign_err", {31'b0, err}, 32'd1);
    chk("misalign_halt", {31'b0, halt}, 32'd1);
    chk("misalign_pc", pc, 32'h1000);

    // PC wrap at the top of the address space.
    do_reset();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    chk("wrap_flush", {31'b0, flush}, 32'd1);
    tick();
    redirect_valid = 1'b0; #1;
    chk("wrap_top_pc", pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_zero_pc", pc, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
